// File: rtl/scale_addr_gen.sv
// scale_addr_gen: source-address sequencer for the image scaling datapath.
// Walks the destination raster for block-average, nearest-neighbour zoom
// in/out and pixel replication, streaming one linear source address per
// valid/ready transfer along with coordinate and block-boundary tags.
// All address arithmetic is incremental (bases advanced by W or f*W), and
// destination dimensions for the shrinking modes are found by repeated
// subtraction rather than division.
module scale_addr_gen #(
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 20,
  parameter int FACT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DIM_W-1:0]  src_w,
  input  logic [DIM_W-1:0]  src_h,
  input  logic [FACT_W-1:0] factor,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [DIM_W-1:0]  dst_row,
  output logic [DIM_W-1:0]  dst_col,
  output logic [FACT_W-1:0] sub_x,
  output logic [FACT_W-1:0] sub_y,
  output logic              blk_first,
  output logic              blk_last,
  output logic              busy,
  output logic              frame_done,
  output logic              cfg_err
);

  localparam int PW = DIM_W + FACT_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] M_AVG  = 2'd0;
  localparam logic [1:0] M_ZIN  = 2'd1;
  localparam logic [1:0] M_ZOUT = 2'd2;
  localparam logic [1:0] M_REP  = 2'd3;

  logic [1:0]        state_reg;
  logic [1:0]        mode_reg;
  logic [DIM_W-1:0]  w_reg;
  logic [FACT_W-1:0] f_reg;
  logic [ADDR_W-1:0] fw_reg;
  logic [DIM_W-1:0]  rem_w_reg, rem_h_reg;
  logic [DIM_W-1:0]  dw_reg, dh_reg;
  logic [DIM_W-1:0]  row_reg, col_reg;
  logic [FACT_W-1:0] sub_x_reg, sub_y_reg;
  logic [FACT_W-1:0] row_ph_reg, col_ph_reg;
  logic [ADDR_W-1:0] row_base_reg;   // address of the first source line of the current output row
  logic [ADDR_W-1:0] line_base_reg;  // row_base plus sub_y*W (block-average only)
  logic [ADDR_W-1:0] col_off_reg;    // source column of the current output pixel
  logic              cfg_err_reg;

  // Start-time configuration checks; the zoom-in products double as the
  // destination dimensions and the saturation test.
  logic [PW-1:0]     prod_w, prod_h;
  logic [DIM_W-1:0]  f_in_dim;
  logic              sat;
  logic              cfg_bad;

  assign prod_w   = PW'(src_w) * PW'(factor);
  assign prod_h   = PW'(src_h) * PW'(factor);
  assign f_in_dim = DIM_W'(factor);
  assign sat      = (prod_w > PW'({DIM_W{1'b1}})) || (prod_h > PW'({DIM_W{1'b1}}));

  // Reject degenerate configurations before any state is committed.
  always_comb begin
    cfg_bad = 1'b0;
    if (factor == '0 || src_w == '0 || src_h == '0)
      cfg_bad = 1'b1;
    if ((mode == M_AVG || mode == M_ZOUT) && (f_in_dim > src_w || f_in_dim > src_h))
      cfg_bad = 1'b1;
    if (mode == M_ZIN && sat)
      cfg_bad = 1'b1;
  end

  // Raster position decode for the current address.
  logic [FACT_W-1:0] f_last;
  logic [DIM_W-1:0]  f_dim;
  logic              setup_done;
  logic              px_done, col_end, row_end, frame_end;
  logic [ADDR_W-1:0] col_step, row_step;

  assign f_last     = f_reg - 1'b1;
  assign f_dim      = DIM_W'(f_reg);
  assign setup_done = (rem_w_reg < f_dim) && (rem_h_reg < f_dim);
  assign px_done    = (mode_reg != M_AVG) || (sub_x_reg == f_last && sub_y_reg == f_last);
  assign col_end    = (col_reg == dw_reg - 1'b1);
  assign row_end    = (row_reg == dh_reg - 1'b1);
  assign frame_end  = px_done && col_end && row_end;

  // Per-mode increments applied when the raster moves to the next column or row.
  always_comb begin
    col_step = ADDR_W'(f_reg);
    row_step = fw_reg;
    case (mode_reg)
      M_ZIN: begin
        col_step = (col_ph_reg == f_last) ? ADDR_W'(1) : '0;
        row_step = (row_ph_reg == f_last) ? ADDR_W'(w_reg) : '0;
      end
      M_REP: begin
        col_step = ADDR_W'(1);
        row_step = ADDR_W'(w_reg);
      end
      default: ;
    endcase
  end

  // Frame FSM: config latch, dimension setup, raster walk and end-of-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      mode_reg      <= '0;
      w_reg         <= '0;
      f_reg         <= '0;
      fw_reg        <= '0;
      rem_w_reg     <= '0;
      rem_h_reg     <= '0;
      dw_reg        <= '0;
      dh_reg        <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      sub_x_reg     <= '0;
      sub_y_reg     <= '0;
      row_ph_reg    <= '0;
      col_ph_reg    <= '0;
      row_base_reg  <= '0;
      line_base_reg <= '0;
      col_off_reg   <= '0;
      cfg_err_reg   <= 1'b0;
    end else begin
      cfg_err_reg <= start && (state_reg == S_IDLE) && cfg_bad;
      case (state_reg)
        S_IDLE: begin
          if (start && !cfg_bad) begin
            mode_reg <= mode;
            w_reg    <= src_w;
            f_reg    <= factor;
            fw_reg   <= ADDR_W'(prod_w);
            if (mode == M_AVG || mode == M_ZOUT) begin
              rem_w_reg <= src_w;
              rem_h_reg <= src_h;
              dw_reg    <= '0;
              dh_reg    <= '0;
            end else if (mode == M_ZIN) begin
              rem_w_reg <= '0;
              rem_h_reg <= '0;
              dw_reg    <= prod_w[DIM_W-1:0];
              dh_reg    <= prod_h[DIM_W-1:0];
            end else begin
              rem_w_reg <= '0;
              rem_h_reg <= '0;
              dw_reg    <= src_w;
              dh_reg    <= src_h;
            end
            row_reg       <= '0;
            col_reg       <= '0;
            sub_x_reg     <= '0;
            sub_y_reg     <= '0;
            row_ph_reg    <= '0;
            col_ph_reg    <= '0;
            row_base_reg  <= '0;
            line_base_reg <= '0;
            col_off_reg   <= '0;
            state_reg     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (abort) begin
            state_reg <= S_IDLE;
          end else if (setup_done) begin
            state_reg <= S_RUN;
          end else begin
            if (rem_w_reg >= f_dim) begin
              rem_w_reg <= rem_w_reg - f_dim;
              dw_reg    <= dw_reg + 1'b1;
            end
            if (rem_h_reg >= f_dim) begin
              rem_h_reg <= rem_h_reg - f_dim;
              dh_reg    <= dh_reg + 1'b1;
            end
          end
        end
        S_RUN: begin
          if (abort) begin
            state_reg <= S_IDLE;
          end else if (addr_ready) begin
            if (frame_end) begin
              state_reg <= S_DONE;
            end else if (mode_reg == M_AVG && sub_x_reg != f_last) begin
              sub_x_reg <= sub_x_reg + 1'b1;
            end else if (mode_reg == M_AVG && sub_y_reg != f_last) begin
              sub_x_reg     <= '0;
              sub_y_reg     <= sub_y_reg + 1'b1;
              line_base_reg <= line_base_reg + ADDR_W'(w_reg);
            end else begin
              sub_x_reg <= '0;
              sub_y_reg <= '0;
              if (!col_end) begin
                col_reg       <= col_reg + 1'b1;
                col_off_reg   <= col_off_reg + col_step;
                col_ph_reg    <= (col_ph_reg == f_last) ? '0 : col_ph_reg + 1'b1;
                line_base_reg <= row_base_reg;
              end else begin
                col_reg       <= '0;
                col_off_reg   <= '0;
                col_ph_reg    <= '0;
                row_reg       <= row_reg + 1'b1;
                row_ph_reg    <= (row_ph_reg == f_last) ? '0 : row_ph_reg + 1'b1;
                row_base_reg  <= row_base_reg + row_step;
                line_base_reg <= row_base_reg + row_step;
              end
            end
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign addr       = line_base_reg + col_off_reg + ADDR_W'(sub_x_reg);
  assign addr_valid = (state_reg == S_RUN);
  assign dst_row    = row_reg;
  assign dst_col    = col_reg;
  assign sub_x      = sub_x_reg;
  assign sub_y      = sub_y_reg;
  assign blk_first  = addr_valid && ((mode_reg != M_AVG) || (sub_x_reg == '0 && sub_y_reg == '0));
  assign blk_last   = addr_valid && px_done;
  assign busy       = (state_reg != S_IDLE);
  assign frame_done = (state_reg == S_DONE);
  assign cfg_err    = cfg_err_reg;

endmodule

// File: doc/scale_addr_gen.md
Name: scale_addr_gen

Overview:
- Parametrised source-address sequencer for the image scaling datapath; successor to the fixed-width row/col generator.
- Walks the output (or input) raster for four scaling modes.
- Generates the block-averaging sub-offsets internally, so no external dx/dy is needed.
- Streams one source-pixel address per transfer over a valid/ready handshake to the fetch/ALU stage, with per-address coordinate and block-boundary tags.

Parameters:
- DIM_W, 10, width of image dimension inputs and coordinate outputs.
- ADDR_W, 20, width of the linear source address.
- FACT_W, 4, width of the scale factor.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches config and begins a frame when idle
- abort  in  1  synchronous; ends the frame immediately
- mode  in  2  0 block-avg, 1 NN zoom-in, 2 NN zoom-out, 3 pixel replication
- src_w  in  DIM_W  source width W
- src_h  in  DIM_H  source height H (DIM_H = DIM_W)
- factor  in  FACT_W  scale factor f
- addr  out  ADDR_W  linear source address
- addr_valid  out  1  addr and tags are valid
- addr_ready  in  1  consumer accepts addr this cycle
- dst_row  out  DIM_W  destination row (source row in mode 3)
- dst_col  out  DIM_W  destination column (source column in mode 3)
- sub_x  out  FACT_W  block sub-column; 0 outside mode 0
- sub_y  out  FACT_W  block sub-row; 0 outside mode 0
- blk_first  out  1  first address of the output pixel's group
- blk_last  out  1  last address of the output pixel's group
- busy  out  1  frame in progress, including setup
- frame_done  out  1  one-cycle pulse at frame end
- cfg_err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE.
- FSM states: IDLE -> SETUP -> RUN -> DONE -> IDLE.
- IDLE: on start, latch mode/src_w/src_h/factor.
  - Reject the start if f==0, W==0, H==0, or (mode 0/2 and f>W or f>H).
  - Rejection: cfg_err pulses the next cycle, FSM stays in IDLE, busy stays 0.
  - Accepted start: go to SETUP; busy=1 from the next cycle.
  - start while busy is ignored.
- SETUP: compute destination dims DW, DH.
  - Modes 0/2: DW=floor(W/f), DH=floor(H/f), by sequential subtraction; no divider.
  - Mode 1: DW=W*f, DH=H*f.
  - Mode 3: DW=W, DH=H.
  - SETUP lasts at most max(W,H)+2 cycles; first addr_valid follows it.
- RUN, output raster: row-major over dst_row 0..DH-1, dst_col 0..DW-1.
  - Mode 0: per output pixel, emit f*f addresses with sub_x as the inner loop, then sub_y. addr=(row*f+sub_y)*W+col*f+sub_x.
  - Mode 1: addr=floor(row/f)*W+floor(col/f). Tracked with phase counters; no division.
  - Mode 2: addr=row*f*W+col*f.
  - Mode 3: addr=row*W+col.
  - Modes 1/2/3: blk_first=blk_last=1 on every address.
  - Mode 0: blk_first when sub_x=sub_y=0; blk_last when sub_x=sub_y=f-1.
- Handshake:
  - Transfer occurs when addr_valid && addr_ready.
  - addr and tags stay stable while valid && !ready.
  - After a transfer, the next address is valid the following cycle, giving 1 address/cycle sustained when ready is held high.
  - addr_valid never drops without a transfer, except on abort or reset.
- End of frame:
  - The transfer of the last address (row=DH-1, col=DW-1, and the last sub-offset in mode 0) moves the FSM to DONE.
  - addr_valid=0 the next cycle; frame_done=1 that same cycle; busy=0 the cycle after.
  - A start in the frame_done cycle is ignored.
- Abort (any non-IDLE state): next cycle addr_valid=0, busy=0, FSM in IDLE; no frame_done. abort has priority over a simultaneous transfer.
- Width rules:
  - Address arithmetic is ADDR_W bits, computed incrementally (row base += f*W or W) so it is exact for W*H <= 2^ADDR_W.
  - Mode 1 DW/DH saturate at 2^DIM_W-1; if saturation occurs, cfg_err pulses and the start is rejected.
- Reset mid-frame: immediate return to reset values; no frame_done.

Test Plan:
- Mode 0, W=H=4, f=2, ready=1 -> 16 addrs 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15; blk_first on addrs 0,2,8,10; blk_last on 5,7,13,15; one frame_done; addresses on 16 consecutive cycles.
- Mode 1, W=H=2, f=2 -> 16 addrs 0,0,1,1,0,0,1,1,2,2,3,3,2,2,3,3; dst_row/col span 0..3.
- Mode 2, W=H=5, f=2 -> DW=DH=2, addrs 0,2,10,12; mode 3, W=3, H=2 -> addrs 0..5, dst_col 0..2.
- Backpressure: mode 3, W=H=2, ready toggled 1010... plus random stalls -> addr/tags stable during stalls; exact sequence 0,1,2,3; frame_done once.
- Config errors: f=0 -> cfg_err pulse, busy stays 0. Mode 0 with f=5, W=4 -> cfg_err. start during busy -> ignored, frame unchanged.
- Abort after 3 transfers in mode 0 -> valid=0 and busy=0 next cycle, no frame_done. A new start then restarts from addr 0. An rst_n assert mid-frame gives all outputs 0.
